maxpool2x2_stream: RTL and testbench

MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_line_buffer.sv | 27 ++
 rtl/maxpool2x2_stream.sv | 151 +++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling stream: FSM state encodings,
// default Q8.8 sample format, and a counter-width helper.
package pool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_FRAC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_e;

    // $clog2 of a bound, but never narrower than one bit so a bound of 1 still
    // yields a legal vector.
    function automatic int cnt_width(input int bound);
        return (bound <= 1) ? 1 : $clog2(bound);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row store of horizontal maxima: synchronous write, combinational read.
// Contents are never reset; every entry is written on an even row before it
// is read on the following odd row.
module pool_line_buffer #(
    parameter int DEPTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max pooling over channel-major raster planes of
// signed samples; one pooled sample per 2x2 window, one cycle after its last input.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int IMG_HEIGHT = 256,
    parameter int IMG_WIDTH  = 256,
    parameter int CHANNELS   = 64,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] feature_in,
    input  logic                  feature_valid,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  pool_valid,
    output logic                  pool_done
);

    localparam int COL_W    = cnt_width(IMG_WIDTH);
    localparam int ROW_W    = cnt_width(IMG_HEIGHT);
    localparam int CH_W     = cnt_width(CHANNELS);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_AW    = cnt_width(LB_DEPTH);

    pool_state_e           state_reg;
    logic [COL_W-1:0]      col_reg;
    logic [ROW_W-1:0]      row_reg;
    logic [CH_W-1:0]       ch_reg;
    logic [DATA_WIDTH-1:0] held_reg;
    logic [DATA_WIDTH-1:0] pool_out_reg;
    logic                  pool_valid_reg;
    logic                  pool_done_reg;

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  ch_last;
    logic                  lb_we;
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] lb_rd_data;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] win_max;

    // Ties resolve to the first operand; equal values are identical bits anyway.
    function automatic logic [DATA_WIDTH-1:0] smax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign accept   = feature_valid && (state_reg == RUN);
    assign col_last = (col_reg == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row_reg == ROW_W'(IMG_HEIGHT - 1));
    assign ch_last  = (ch_reg == CH_W'(CHANNELS - 1));

    // Column pair index: entry col/2 holds the even-row maximum of that pair.
    assign lb_addr  = LB_AW'(col_reg >> 1);
    assign hmax     = smax(held_reg, feature_in);
    assign win_max  = smax(hmax, lb_rd_data);
    assign lb_we    = accept && col_reg[0] && !row_reg[0];

    pool_line_buffer #(
        .DEPTH      (LB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            ch_reg         <= '0;
            held_reg       <= '0;
            pool_out_reg   <= '0;
            pool_valid_reg <= 1'b0;
            pool_done_reg  <= 1'b0;
        end else begin
            pool_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        ch_reg    <= '0;
                    end
                end

                RUN: begin
                    if (accept) begin
                        if (!col_reg[0]) begin
                            held_reg <= feature_in;
                        end
                        if (col_reg[0] && row_reg[0]) begin
                            pool_out_reg   <= win_max;
                            pool_valid_reg <= 1'b1;
                        end
                        if (col_last) begin
                            col_reg <= '0;
                            if (row_last) begin
                                row_reg <= '0;
                                if (ch_last) begin
                                    ch_reg        <= '0;
                                    state_reg     <= DONE;
                                    pool_done_reg <= 1'b1;
                                end else begin
                                    ch_reg <= ch_reg + 1'b1;
                                end
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (start) begin
                        state_reg     <= RUN;
                        pool_done_reg <= 1'b0;
                        col_reg       <= '0;
                        row_reg       <= '0;
                        ch_reg        <= '0;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    pool_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pool_out   = pool_out_reg;
    assign pool_valid = pool_valid_reg;
    assign pool_done  = pool_done_reg;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on 4x4x2 frames; expected window maxima
// are queued when the closing sample is driven and checked on each pulse.
module tb_maxpool2x2_stream;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int C  = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] feature_in = '0;
    logic          feature_valid = 1'b0;
    logic [DW-1:0] pool_out;
    logic          pool_valid;
    logic          pool_done;

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_pulses = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] plane_data [H*W];

    maxpool2x2_stream #(
        .IMG_HEIGHT (H),
        .IMG_WIDTH  (W),
        .CHANNELS   (C),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .feature_in    (feature_in),
        .feature_valid (feature_valid),
        .pool_out      (pool_out),
        .pool_valid    (pool_valid),
        .pool_done     (pool_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pool_valid === 1'b1) begin
            logic [DW-1:0] e;
            n_pulses++;
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pool_out", 32'(pool_out), 32'(e));
                $display("pulse %0d: pool_out=%0h expected=%0h", n_pulses, pool_out, e);
            end
        end
    end

    function automatic logic [DW-1:0] window_max(input int r, input int c);
        int m;
        int v;
        m = $signed(plane_data[r*W + c]);
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = $signed(plane_data[(r+dr)*W + c + dc]);
                if (v > m) m = v;
            end
        end
        return DW'(m);
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d);
        feature_valid = v;
        feature_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int i);
        if (((i / W) % 2 == 1) && ((i % W) % 2 == 1))
            exp_q.push_back(window_max(i / W - 1, i % W - 1));
        step(1'b1, plane_data[i]);
    endtask

    task automatic send_plane(input bit gaps);
        for (int i = 0; i < H*W; i++) begin
            send_sample(i);
            if (gaps) step(1'b0, 16'hDEAD);
        end
    endtask

    task automatic pulse_start();
        feature_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        feature_valid = 1'b0;
        repeat (3) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < H*W; i++) plane_data[i] = DW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pool_out", 32'(pool_out), 32'd0);
        check("rst_pool_valid", 32'(pool_valid), 32'd0);
        check("rst_pool_done", 32'(pool_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Valid samples in IDLE are ignored
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(i + 50));
            @(negedge clk);
            check("idle_no_pulse", 32'(pool_valid), 32'd0);
        end

        // Frame 1: plane 0 = 0..15, plane 1 = negative Q8.8 values
        pulse_start();
        for (int i = 0; i < H*W; i++) plane_data[i] = DW'(i);
        send_plane(1'b0);
        for (int i = 0; i < H*W; i++) plane_data[i] = DW'(-(i + 1) * 256);
        send_plane(1'b0);
        @(negedge clk);
        check("final_pulse", 32'(pool_valid), 32'd1);
        check("done_with_final_pulse", 32'(pool_done), 32'd1);
        drain("drain_frame1");
        check("done_held", 32'(pool_done), 32'd1);

        // Frame 2 from DONE: alternate valid, identical data in both planes
        pulse_start();
        @(negedge clk);
        check("done_drops_on_run", 32'(pool_done), 32'd0);
        base = n_pulses;
        fill_random();
        send_plane(1'b1);
        send_plane(1'b1);
        drain("drain_frame2");
        check("frame2_pulse_count", 32'(n_pulses - base), 32'd8);
        check("frame2_done", 32'(pool_done), 32'd1);

        // Frame 3: reset after 9 samples, then a clean frame 100..115
        pulse_start();
        fill_random();
        for (int i = 0; i < 9; i++) send_sample(i);
        @(negedge clk);
        check("partial_drained", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_pool_valid", 32'(pool_valid), 32'd0);
        check("midrst_pool_done", 32'(pool_done), 32'd0);
        check("midrst_pool_out", 32'(pool_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_start();
        base = n_pulses;
        for (int i = 0; i < H*W; i++) plane_data[i] = DW'(100 + i);
        send_plane(1'b0);
        fill_random();
        send_plane(1'b0);
        drain("drain_frame3");
        check("frame3_pulse_count", 32'(n_pulses - base), 32'd8);
        check("frame3_done", 32'(pool_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
